// File: rtl/adc_frame_avg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adc_pkg
// Description : Shared constants and types for the ADC frame averager.
//               ADC_W        - sample width in bits
//               LOG2_N_MAX   - largest supported log2 block length
//               ADC_MIN_INIT - running-minimum start value (all ones)
//               state_t      - acquisition state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    localparam int ADC_W      = 12;
    localparam int LOG2_N_MAX = 8;

    localparam logic [ADC_W-1:0] ADC_MIN_INIT = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_frame_avg_if.sv
`default_nettype none
// ============================================================================
// Interface   : adc_frame_avg_if
// Description : Block-result valid/ready channel towards the telemetry stage.
//               out_valid - result available        (master -> slave)
//               out_ready - consumer accepts result (slave  -> master)
//               out_mean  - truncated block mean    (master -> slave)
//               out_min   - block minimum           (master -> slave)
//               out_max   - block maximum           (master -> slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_frame_avg_if #(
    parameter int ADC_W = adc_pkg::ADC_W
) ();

    logic             out_valid;
    logic             out_ready;
    logic [ADC_W-1:0] out_mean;
    logic [ADC_W-1:0] out_min;
    logic [ADC_W-1:0] out_max;

    modport master (
        output out_valid,
        output out_mean,
        output out_min,
        output out_max,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_mean,
        input  out_min,
        input  out_max,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/adc_frame_avg_edge_fall_det.sv
`default_nettype none
// ============================================================================
// Module      : edge_fall_det
// Description : Registered falling-edge detector. o_fall is high in the cycle
//               where i_sig is low and was high on the previous clock.
//               clk    - clock, rising edge
//               rst    - synchronous active-high reset (delayed copy -> 0)
//               i_sig  - monitored signal
//               o_fall - falling-edge strobe
// Revision    : 1.0 - initial release
// ============================================================================
module edge_fall_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_fall
);

    logic r_sig_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_fall = r_sig_d & ~i_sig;

endmodule
`default_nettype wire

// File: rtl/adc_frame_avg.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_avg
// Description : Captures one ADC sample per conversion frame (CS falling
//               edge), accumulates 2**LOG2_N samples and presents the block
//               mean/min/max on a valid/ready channel.
//               clk_25   - 25 MHz system clock
//               reset    - synchronous active-high reset
//               start    - acquisition enable
//               cs       - ADC chip-select; falling edge marks a sample
//               adc_data - sample bus, valid in the CS falling cycle
//               res      - result channel (master side)
//               out_ovf  - sticky: a block result was dropped
//               busy     - a block is accumulating
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_avg #(
    parameter int ADC_W  = 12,
    parameter int LOG2_N = 4
) (
    input  logic                  clk_25,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cs,
    input  logic [ADC_W-1:0]      adc_data,
    adc_frame_avg_if.master       res,
    output logic                  out_ovf,
    output logic                  busy
);

    import adc_pkg::*;

    // Out-of-range block lengths are clamped to the largest supported one.
    localparam int c_LOG2_N = (LOG2_N > LOG2_N_MAX) ? LOG2_N_MAX : LOG2_N;
    // N samples of at most 2**ADC_W-1 always fit in ADC_W+log2(N) bits.
    localparam int c_SUM_W  = ADC_W + c_LOG2_N;
    // A one-sample block still needs a 1-bit counter; it simply stays 0.
    localparam int c_CNT_W  = (c_LOG2_N > 0) ? c_LOG2_N : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << c_LOG2_N) - 1);
    localparam logic [ADC_W-1:0]   c_MIN_INIT = {ADC_W{ADC_MIN_INIT[0]}};

    state_t               r_state;
    state_t               w_state_nxt;

    logic [c_SUM_W-1:0]   r_sum;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [ADC_W-1:0]     r_min;
    logic [ADC_W-1:0]     r_max;

    logic                 r_valid;
    logic [ADC_W-1:0]     r_mean;
    logic [ADC_W-1:0]     r_res_min;
    logic [ADC_W-1:0]     r_res_max;
    logic                 r_ovf;

    logic                 w_fall;
    logic                 w_take;
    logic                 w_close;
    logic                 w_accept;
    logic [c_SUM_W-1:0]   w_sum_nxt;
    logic [ADC_W-1:0]     w_min_nxt;
    logic [ADC_W-1:0]     w_max_nxt;

    edge_fall_det u_cs_fall (
        .clk    (clk_25),
        .rst    (reset),
        .i_sig  (cs),
        .o_fall (w_fall)
    );

    // ------------------------------------------------------------------------
    // Acquisition FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_25) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = ACC;
            ACC:     if (!start) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (r_state == ACC) begin
            busy = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sample accumulation
    // ------------------------------------------------------------------------
    // Samples count only while already in ACC with start still high, so a
    // fall coinciding with the rising start edge is ignored.
    assign w_take    = (r_state == ACC) & start & w_fall;
    assign w_close   = w_take & (r_cnt == c_CNT_LAST);
    assign w_accept  = r_valid & res.out_ready;

    assign w_sum_nxt = r_sum + c_SUM_W'(adc_data);
    assign w_min_nxt = (adc_data < r_min) ? adc_data : r_min;
    assign w_max_nxt = (adc_data > r_max) ? adc_data : r_max;

    // Closing a block restarts the accumulators in the same cycle the result
    // is captured, so the very next frame already belongs to the new block.
    always_ff @(posedge clk_25) begin
        if (reset || !start || w_close) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_min <= c_MIN_INIT;
            r_max <= '0;
        end else if (w_take) begin
            r_sum <= w_sum_nxt;
            r_cnt <= r_cnt + c_CNT_W'(1);
            r_min <= w_min_nxt;
            r_max <= w_max_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Result register and handshake
    // ------------------------------------------------------------------------
    // A new result loads when the slot is free or is being accepted this very
    // cycle; otherwise it is dropped and the overflow flag latches.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_mean    <= '0;
            r_res_min <= '0;
            r_res_max <= '0;
            r_ovf     <= 1'b0;
        end else if (w_close && (!r_valid || res.out_ready)) begin
            r_valid   <= 1'b1;
            r_mean    <= w_sum_nxt[c_SUM_W-1:c_LOG2_N];
            r_res_min <= w_min_nxt;
            r_res_max <= w_max_nxt;
        end else if (w_close) begin
            r_ovf     <= 1'b1;
        end else if (w_accept) begin
            r_valid   <= 1'b0;
        end
    end

    assign res.out_valid = r_valid;
    assign res.out_mean  = r_mean;
    assign res.out_min   = r_res_min;
    assign res.out_max   = r_res_max;
    assign out_ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_frame_avg
// Description : Self-checking bench for adc_frame_avg. Two instances share the
//               ADC-style stimulus: u_dut0 with 4-sample blocks and u_dut1
//               with 1-sample blocks. A queue-based block model predicts the
//               outputs of both, checked on every falling clock edge, and
//               directed scenarios pin hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_avg;

    import adc_pkg::*;

    localparam int N0 = 4;

    logic             clk_25 = 1'b0;
    logic             reset;
    logic             start;
    logic             cs;
    logic [ADC_W-1:0] adc_data;
    logic             out_ovf0, busy0, out_ovf1, busy1;

    int n_checks = 0;
    int n_pass   = 0;
    int smp;
    bit rdy_base;

    always #20 clk_25 = ~clk_25;

    adc_frame_avg_if #(.ADC_W(ADC_W)) if0 ();
    adc_frame_avg_if #(.ADC_W(ADC_W)) if1 ();

    adc_frame_avg #(.ADC_W(ADC_W), .LOG2_N(2)) u_dut0 (
        .clk_25   (clk_25),
        .reset    (reset),
        .start    (start),
        .cs       (cs),
        .adc_data (adc_data),
        .res      (if0),
        .out_ovf  (out_ovf0),
        .busy     (busy0)
    );

    adc_frame_avg #(.ADC_W(ADC_W), .LOG2_N(0)) u_dut1 (
        .clk_25   (clk_25),
        .reset    (reset),
        .start    (start),
        .cs       (cs),
        .adc_data (adc_data),
        .res      (if1),
        .out_ovf  (out_ovf1),
        .busy     (busy1)
    );

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model: samples of the open block kept in a queue; a block
    // closes when the queue holds N0 samples.
    // ------------------------------------------------------------------------
    bit m_init = 0;
    bit m_cs_d, m_acc, m_valid, m_ovf, m1_valid;
    int m_mean, m_min, m_max, m1_val;
    int q[$];

    always @(posedge clk_25) begin : p_model
        bit fall, take, accept, closed;
        int sum, mn, mx;
        if (reset) begin
            m_init = 1; m_cs_d = 0; m_acc = 0; q.delete();
            m_valid = 0; m_ovf = 0; m_mean = 0; m_min = 0; m_max = 0;
            m1_valid = 0; m1_val = 0;
        end else begin
            fall   = m_cs_d && !cs;
            m_cs_d = cs;
            take   = m_acc && start && fall;
            accept = m_valid && if0.out_ready;
            closed = 0;
            m1_valid = take;
            if (take) m1_val = int'(adc_data);
            if (!start) begin
                q.delete();
            end else if (take) begin
                q.push_back(int'(adc_data));
                if (q.size() == N0) begin
                    sum = 0; mn = 1 << ADC_W; mx = -1;
                    foreach (q[i]) begin
                        sum += q[i];
                        if (q[i] < mn) mn = q[i];
                        if (q[i] > mx) mx = q[i];
                    end
                    q.delete();
                    closed = 1;
                    if (m_valid && !if0.out_ready) begin
                        m_ovf = 1;
                    end else begin
                        m_valid = 1; m_mean = sum / N0; m_min = mn; m_max = mx;
                    end
                end
            end
            if (!closed && accept) m_valid = 0;
            m_acc = start;
        end
    end

    always @(negedge clk_25) begin : p_compare
        if (m_init) begin
            chk("valid0", int'(if0.out_valid), int'(m_valid));
            chk("ovf0",   int'(out_ovf0),      int'(m_ovf));
            chk("busy0",  int'(busy0),         int'(m_acc));
            if (m_valid) begin
                chk("mean0", int'(if0.out_mean), m_mean);
                chk("min0",  int'(if0.out_min),  m_min);
                chk("max0",  int'(if0.out_max),  m_max);
            end
            chk("valid1", int'(if1.out_valid), int'(m1_valid));
            chk("busy1",  int'(busy1),         int'(m_acc));
            chk("ovf1",   int'(out_ovf1),      0);
            if (m1_valid) begin
                chk("mean1", int'(if1.out_mean), m1_val);
                chk("min1",  int'(if1.out_min),  m1_val);
                chk("max1",  int'(if1.out_max),  m1_val);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus: one 25-clock ADC frame, CS high on counts 15..23, sample
    // value held for the whole frame. Optional one-cycle ready pulse on the
    // CS falling cycle.
    // ------------------------------------------------------------------------
    task automatic frame(input bit pulse);
        for (int c = 0; c < 25; c++) begin
            @(negedge clk_25);
            if (c == 0) if0.out_ready = rdy_base;
            cs       = (c >= 15 && c <= 23);
            adc_data = ADC_W'(smp);
            if (c == 24 && pulse) if0.out_ready = 1'b1;
        end
        smp++;
    endtask

    task automatic frames(input int n);
        repeat (n) frame(1'b0);
    endtask

    task automatic lit(input string name, input int v, input int mean, input int mn, input int mx);
        @(negedge clk_25);
        chk({name, ".valid"}, int'(if0.out_valid), v);
        chk({name, ".mean"},  int'(if0.out_mean),  mean);
        chk({name, ".min"},   int'(if0.out_min),   mn);
        chk({name, ".max"},   int'(if0.out_max),   mx);
    endtask

    task automatic lit_reset(input string name);
        chk({name, ".valid"}, int'(if0.out_valid), 0);
        chk({name, ".mean"},  int'(if0.out_mean),  0);
        chk({name, ".min"},   int'(if0.out_min),   0);
        chk({name, ".max"},   int'(if0.out_max),   0);
        chk({name, ".ovf"},   int'(out_ovf0),      0);
        chk({name, ".busy"},  int'(busy0),         0);
        chk({name, ".valid1"}, int'(if1.out_valid), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cs = 1'b0; adc_data = '0;
        if0.out_ready = 1'b1; if1.out_ready = 1'b1;
        rdy_base = 1'b1; smp = 1;
        repeat (3) @(negedge clk_25);
        lit_reset("reset");

        // 1: samples 1..4, one-cycle result pulse; 1-sample instance echoes 1
        reset = 1'b0; start = 1'b1;
        frames(1);
        @(negedge clk_25);
        chk("n1.valid", int'(if1.out_valid), 1);
        chk("n1.mean",  int'(if1.out_mean),  1);
        chk("n1.min",   int'(if1.out_min),   1);
        chk("n1.max",   int'(if1.out_max),   1);
        frames(3);
        lit("blk1", 1, 2, 1, 4);
        @(negedge clk_25);
        chk("blk1.pulse_end", int'(if0.out_valid), 0);

        // 2: the next block starts with the very next frame
        frames(4);
        lit("blk2", 1, 6, 5, 8);
        @(negedge clk_25);
        chk("blk2.pulse_end", int'(if0.out_valid), 0);

        // 3: consumer stalls for two blocks -> first held, overflow flagged
        rdy_base = 1'b0;
        frames(4);
        lit("stall1", 1, 10, 9, 12);
        frames(4);
        lit("stall2_held", 1, 10, 9, 12);
        chk("stall2.ovf", int'(out_ovf0), 1);
        if0.out_ready = 1'b1;
        @(negedge clk_25);
        @(negedge clk_25);
        chk("stall.drain", int'(if0.out_valid), 0);
        chk("stall.ovf_sticky", int'(out_ovf0), 1);

        reset = 1'b1; start = 1'b0;
        @(negedge clk_25);
        lit_reset("reset2");

        // 4: start dropped after two samples -> partial block discarded
        reset = 1'b0; start = 1'b1; rdy_base = 1'b1;
        frames(2);
        @(negedge clk_25);
        start = 1'b0;
        repeat (3) @(negedge clk_25);
        chk("idle.busy", int'(busy0), 0);
        start = 1'b1;
        frames(4);
        lit("restart", 1, 20, 19, 22);
        @(negedge clk_25);
        chk("restart.pulse_end", int'(if0.out_valid), 0);

        // 5: close coincident with accept -> new result loads, no overflow
        rdy_base = 1'b0;
        frames(4);
        lit("coin_first", 1, 24, 23, 26);
        frames(3);
        frame(1'b1);
        lit("coin_new", 1, 28, 27, 30);
        chk("coin.ovf", int'(out_ovf0), 0);
        @(negedge clk_25);
        chk("coin.drain", int'(if0.out_valid), 0);

        // 6: reset after three samples, then a full fresh block
        rdy_base = 1'b1;
        frames(3);
        reset = 1'b1;
        @(negedge clk_25);
        lit_reset("reset3");
        reset = 1'b0;
        frames(4);
        lit("after_reset", 1, 35, 34, 37);

        repeat (3) @(negedge clk_25);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
